// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory port of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned DATAW = 32
);
    // Port A: CPU load/store stage
    logic             a_req;
    logic             a_we;
    logic [DATAW-1:0] a_addr;
    logic [DATAW-1:0] a_wd;
    logic [DATAW-1:0] a_rdata;
    logic             a_done;
    logic             a_err;

    // Port B: debug/loader
    logic             b_req;
    logic             b_we;
    logic [DATAW-1:0] b_addr;
    logic [DATAW-1:0] b_wd;
    logic [DATAW-1:0] b_rdata;
    logic             b_done;
    logic             b_err;

    // Single-port memory, combinational read
    logic [DATAW-1:0] mem_address;
    logic [DATAW-1:0] mem_wd;
    logic             mem_we;
    logic [DATAW-1:0] mem_rd;

    // Requesters and memory model side
    modport master (
        output a_req, a_we, a_addr, a_wd,
        input  a_rdata, a_done, a_err,
        output b_req, b_we, b_addr, b_wd,
        input  b_rdata, b_done, b_err,
        input  mem_address, mem_wd, mem_we,
        output mem_rd
    );

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wd,
        output a_rdata, a_done, a_err,
        input  b_req, b_we, b_addr, b_wd,
        output b_rdata, b_done, b_err,
        output mem_address, mem_wd, mem_we,
        input  mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and 3-cycle sequencer (grant, access, respond) for a
// single-port word-addressed data memory shared by the CPU (A) and debug (B) ports.
module dmem_arbiter #(
    parameter int unsigned MEM   = 64,
    parameter int unsigned DATAW = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_last_grant;
    logic             r_cur_port;
    logic             r_cur_we;
    logic [DATAW-1:0] r_cur_addr;
    logic [DATAW-1:0] r_cur_wd;
    logic             r_mem_we;
    logic             r_a_done;
    logic             r_a_err;
    logic             r_b_done;
    logic             r_b_err;
    logic [DATAW-1:0] r_a_rdata;
    logic [DATAW-1:0] r_b_rdata;

    logic             w_last_grant_nxt;
    logic             w_cur_port_nxt;
    logic             w_cur_we_nxt;
    logic [DATAW-1:0] w_cur_addr_nxt;
    logic [DATAW-1:0] w_cur_wd_nxt;
    logic             w_mem_we_nxt;
    logic             w_a_done_nxt;
    logic             w_a_err_nxt;
    logic             w_b_done_nxt;
    logic             w_b_err_nxt;
    logic [DATAW-1:0] w_a_rdata_nxt;
    logic [DATAW-1:0] w_b_rdata_nxt;

    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_sel_we;
    logic [DATAW-1:0] w_sel_addr;
    logic [DATAW-1:0] w_sel_wd;
    logic             w_sel_in_range;
    logic             w_cur_in_range;

    // Round-robin choice: on a tie the port that was not granted last wins
    assign w_grant_a = bus.a_req & (~bus.b_req | (r_last_grant == PORT_B));
    assign w_grant_b = bus.b_req & ~w_grant_a;

    // Request fields of the winning port
    assign w_sel_we   = w_grant_a ? bus.a_we   : bus.b_we;
    assign w_sel_addr = w_grant_a ? bus.a_addr : bus.b_addr;
    assign w_sel_wd   = w_grant_a ? bus.a_wd   : bus.b_wd;

    // Full-width unsigned range checks, so high address bits can never alias into memory
    assign w_sel_in_range = (w_sel_addr < DATAW'(MEM));
    assign w_cur_in_range = (r_cur_addr < DATAW'(MEM));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of the captured request and response registers
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_cur_port_nxt   = r_cur_port;
        w_cur_we_nxt     = r_cur_we;
        w_cur_addr_nxt   = r_cur_addr;
        w_cur_wd_nxt     = r_cur_wd;
        w_mem_we_nxt     = 1'b0;
        w_a_done_nxt     = 1'b0;
        w_a_err_nxt      = 1'b0;
        w_b_done_nxt     = 1'b0;
        w_b_err_nxt      = 1'b0;
        w_a_rdata_nxt    = r_a_rdata;
        w_b_rdata_nxt    = r_b_rdata;

        case (r_state)
            S_IDLE: begin
                if (w_grant_a || w_grant_b) begin
                    w_cur_port_nxt   = w_grant_a ? PORT_A : PORT_B;
                    w_last_grant_nxt = w_grant_a ? PORT_A : PORT_B;
                    w_cur_we_nxt     = w_sel_we;
                    w_cur_addr_nxt   = w_sel_addr;
                    w_cur_wd_nxt     = w_sel_wd;
                    // mem_we is high for the whole ACCESS cycle only for in-range stores
                    w_mem_we_nxt     = w_sel_we & w_sel_in_range;
                    w_state_nxt      = S_ACCESS;
                end
            end

            S_ACCESS: begin
                w_state_nxt = S_RESP;
                if (w_cur_in_range) begin
                    if (r_cur_port == PORT_A) begin
                        w_a_done_nxt = 1'b1;
                        if (!r_cur_we) begin
                            w_a_rdata_nxt = bus.mem_rd;
                        end
                    end else begin
                        w_b_done_nxt = 1'b1;
                        if (!r_cur_we) begin
                            w_b_rdata_nxt = bus.mem_rd;
                        end
                    end
                end else begin
                    w_a_err_nxt = (r_cur_port == PORT_A);
                    w_b_err_nxt = (r_cur_port == PORT_B);
                end
            end

            S_RESP: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Captured request, memory drive and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= PORT_B;
            r_cur_port   <= PORT_A;
            r_cur_we     <= 1'b0;
            r_cur_addr   <= '0;
            r_cur_wd     <= '0;
            r_mem_we     <= 1'b0;
            r_a_done     <= 1'b0;
            r_a_err      <= 1'b0;
            r_b_done     <= 1'b0;
            r_b_err      <= 1'b0;
            r_a_rdata    <= '0;
            r_b_rdata    <= '0;
        end else begin
            r_last_grant <= w_last_grant_nxt;
            r_cur_port   <= w_cur_port_nxt;
            r_cur_we     <= w_cur_we_nxt;
            r_cur_addr   <= w_cur_addr_nxt;
            r_cur_wd     <= w_cur_wd_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_a_done     <= w_a_done_nxt;
            r_a_err      <= w_a_err_nxt;
            r_b_done     <= w_b_done_nxt;
            r_b_err      <= w_b_err_nxt;
            r_a_rdata    <= w_a_rdata_nxt;
            r_b_rdata    <= w_b_rdata_nxt;
        end
    end

    // The write enable is gated by reset so a reset landing in ACCESS cancels the commit
    assign bus.mem_we      = r_mem_we & ~reset;
    assign bus.mem_address = r_cur_addr;
    assign bus.mem_wd      = r_cur_wd;

    assign bus.a_done  = r_a_done;
    assign bus.a_err   = r_a_err;
    assign bus.a_rdata = r_a_rdata;
    assign bus.b_done  = r_b_done;
    assign bus.b_err   = r_b_err;
    assign bus.b_rdata = r_b_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected responses
// and memory writes; a negedge monitor pops and compares whatever the DUT presents.
module tb_dmem_arbiter;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.DATAW(32)) bus ();

    dmem_arbiter #(.MEM(64), .DATAW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on posedge
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (bus.mem_we && (bus.mem_address < 32'd64)) mem[bus.mem_address[5:0]] <= bus.mem_wd;
    end
    assign bus.mem_rd = (bus.mem_address < 32'd64) ? mem[bus.mem_address[5:0]] : 32'd0;

    typedef struct {
        int          port;
        bit          err;
        bit          chk_rd;
        logic [31:0] rd;
        int          lat;   // cycles from req assertion to pulse, 0 = not checked
        int          gap;   // cycles since previous pulse, 0 = not checked
    } resp_t;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
    } wr_t;

    resp_t qresp[$];
    wr_t   qw[$];

    int cyc = 0;
    int issue_cyc [2];
    int checks = 0;
    int errors = 0;
    int last_resp_cyc = 0;
    int age = 0;
    bit mon_en = 1'b0;
    bit quiet  = 1'b0;
    bit fin    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic exp_resp(input int port, input bit err, input bit chk_rd,
                            input logic [31:0] rd, input int lat, input int gap);
        resp_t r;
        r = '{port, err, chk_rd, rd, lat, gap};
        qresp.push_back(r);
    endtask

    task automatic exp_wr(input int port, input logic [31:0] addr, input logic [31:0] wd, input int lat);
        wr_t w;
        w = '{port, addr, wd, lat};
        qw.push_back(w);
    endtask

    // Issue one transaction at a negedge, hold until done/err, drop req, return at the next negedge
    task automatic drive(input int port, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        bit seen;
        if (port == 0) begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wd = wd;
        end else begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wd = wd;
        end
        issue_cyc[port] = cyc;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            seen = (port == 0) ? (bus.a_done | bus.a_err) : (bus.b_done | bus.b_err);
            if (seen) break;
        end
        if (port == 0) bus.a_req = 1'b0;
        else           bus.b_req = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: compares every pulse and every memory write against the queues
    always @(negedge clk) begin
        logic        pd, pe;
        logic [31:0] prd;
        resp_t       r;
        wr_t         w;
        if (mon_en) begin
            if (quiet) begin
                chk("reset_quiet",
                    {27'd0, bus.a_done, bus.a_err, bus.b_done, bus.b_err, bus.mem_we}
                    | bus.a_rdata | bus.b_rdata | bus.mem_address | bus.mem_wd, 32'd0);
            end

            if (bus.mem_we) begin
                if (qw.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write got addr=%h wd=%h want no write (cycle %0d)",
                             bus.mem_address, bus.mem_wd, cyc);
                end else begin
                    w = qw.pop_front();
                    chk("wr_addr", bus.mem_address, w.addr);
                    chk("wr_data", bus.mem_wd, w.wd);
                    if (w.lat > 0) chk("wr_lat", 32'(cyc - issue_cyc[w.port]), 32'(w.lat));
                end
            end

            for (int p = 0; p < 2; p++) begin
                pd  = (p == 0) ? bus.a_done  : bus.b_done;
                pe  = (p == 0) ? bus.a_err   : bus.b_err;
                prd = (p == 0) ? bus.a_rdata : bus.b_rdata;
                if (pd || pe) begin
                    if (qresp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp got port=%0d done=%b err=%b want none (cycle %0d)",
                                 p, pd, pe, cyc);
                    end else begin
                        r = qresp.pop_front();
                        chk("grant_port", 32'(p), 32'(r.port));
                        chk("done_err", {30'd0, pd, pe}, {30'd0, ~r.err, r.err});
                        if (r.chk_rd) chk("rdata", prd, r.rd);
                        if (r.lat > 0) chk("resp_lat", 32'(cyc - issue_cyc[p]), 32'(r.lat));
                        if (r.gap > 0) chk("resp_gap", 32'(cyc - last_resp_cyc), 32'(r.gap));
                    end
                    last_resp_cyc = cyc;
                    age = 0;
                end
            end

            if (qresp.size() > 0) begin
                age++;
                if (age > 14) begin
                    checks++; errors++;
                    $display("FAIL resp_timeout got no pulse want port=%0d (cycle %0d)", qresp[0].port, cyc);
                    void'(qresp.pop_front());
                    age = 0;
                end
            end else begin
                age = 0;
            end

            if (fin) begin
                chk("resp_queue_empty", 32'(qresp.size()), 32'd0);
                chk("wr_queue_empty", 32'(qw.size()), 32'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    // Directed stimulus
    initial begin
        reset = 1'b1;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wd = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wd = '0;
        issue_cyc[0] = 0;
        issue_cyc[1] = 0;

        // Reset for 2 cycles then idle: all outputs zero, no writes
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        quiet  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        quiet = 1'b0;

        // Single store then load on A; B load sets last_grant to B
        exp_wr(0, 32'd5, 32'hDEADBEEF, 1);
        exp_resp(0, 1'b0, 1'b0, 32'd0, 2, 0);
        drive(0, 1'b1, 32'd5, 32'hDEADBEEF);
        exp_resp(0, 1'b0, 1'b1, 32'hDEADBEEF, 2, 0);
        drive(0, 1'b0, 32'd5, 32'd0);
        exp_resp(1, 1'b0, 1'b1, 32'hDEADBEEF, 2, 0);
        drive(1, 1'b0, 32'd5, 32'd0);

        // Simultaneous stores to address 3: A first, B three cycles later
        exp_wr(0, 32'd3, 32'h11111111, 1);
        exp_wr(1, 32'd3, 32'h22222222, 4);
        exp_resp(0, 1'b0, 1'b0, 32'd0, 2, 0);
        exp_resp(1, 1'b0, 1'b0, 32'd0, 5, 3);
        fork
            drive(0, 1'b1, 32'd3, 32'h11111111);
            drive(1, 1'b1, 32'd3, 32'h22222222);
        join
        exp_resp(1, 1'b0, 1'b1, 32'h22222222, 2, 0);
        drive(1, 1'b0, 32'd3, 32'd0);

        // Sustained contention: 4 loads each, strict alternation every 3 cycles
        exp_resp(0, 1'b0, 1'b1, 32'hDEADBEEF, 2, 0);
        exp_resp(1, 1'b0, 1'b1, 32'h22222222, 5, 3);
        for (int k = 0; k < 3; k++) begin
            exp_resp(0, 1'b0, 1'b1, 32'hDEADBEEF, 5, 3);
            exp_resp(1, 1'b0, 1'b1, 32'h22222222, 5, 3);
        end
        fork
            begin
                for (int k = 0; k < 4; k++) drive(0, 1'b0, 32'd5, 32'd0);
            end
            begin
                for (int k = 0; k < 4; k++) drive(1, 1'b0, 32'd3, 32'd0);
            end
        join

        // Out of range: error pulse, no write, rdata held; boundary addresses 0 and 63
        exp_wr(1, 32'd0, 32'h00C0FFEE, 1);
        exp_resp(1, 1'b0, 1'b0, 32'd0, 2, 0);
        drive(1, 1'b1, 32'd0, 32'h00C0FFEE);
        exp_wr(1, 32'd63, 32'h3F3F3F3F, 1);
        exp_resp(1, 1'b0, 1'b0, 32'd0, 2, 0);
        drive(1, 1'b1, 32'd63, 32'h3F3F3F3F);
        exp_resp(1, 1'b0, 1'b1, 32'h3F3F3F3F, 2, 0);
        drive(1, 1'b0, 32'd63, 32'd0);
        exp_resp(1, 1'b1, 1'b1, 32'h3F3F3F3F, 2, 0);
        drive(1, 1'b1, 32'd64, 32'hFFFFFFFF);
        exp_resp(1, 1'b1, 1'b1, 32'h3F3F3F3F, 2, 0);
        drive(1, 1'b0, 32'd64, 32'd0);
        exp_resp(0, 1'b1, 1'b1, 32'hDEADBEEF, 2, 0);
        drive(0, 1'b1, 32'h80000040, 32'h00001234);
        exp_resp(1, 1'b0, 1'b1, 32'h00C0FFEE, 2, 0);
        drive(1, 1'b0, 32'd0, 32'd0);
        exp_resp(0, 1'b0, 1'b1, 32'h3F3F3F3F, 2, 0);
        drive(0, 1'b0, 32'd63, 32'd0);

        // Reset during the ACCESS cycle of an A store to address 7
        exp_wr(0, 32'd7, 32'h77777777, 1);
        exp_resp(0, 1'b0, 1'b0, 32'd0, 2, 0);
        drive(0, 1'b1, 32'd7, 32'h77777777);
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'd7; bus.a_wd = 32'hBADBAD00;
        issue_cyc[0] = cyc;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.a_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (2) @(negedge clk);
        quiet = 1'b0;
        exp_resp(0, 1'b0, 1'b1, 32'h77777777, 2, 0);
        drive(0, 1'b0, 32'd7, 32'd0);
        exp_resp(1, 1'b0, 1'b1, 32'h77777777, 2, 0);
        drive(1, 1'b0, 32'd7, 32'd0);

        repeat (2) @(negedge clk);
        fin = 1'b1;
        repeat (4) @(negedge clk);
    end

    // Global bound on run time
    initial begin
        #100000;
        $display("FAIL watchdog got no end of test want finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
